// File: rtl/dadd_pkg.sv
// Shared types and limits for the data add/subtract pipeline.
package dadd_pkg;

  typedef enum logic [1:0] {
    DADD_ADD_WRAP = 2'b00,
    DADD_ADD_SAT  = 2'b01,
    DADD_SUB_WRAP = 2'b10,
    DADD_SUB_SAT  = 2'b11
  } dadd_mode_e;

  localparam int DADD_MAX_STAGES = 8;

endpackage

// File: rtl/dadd_stage.sv
// One pipeline register slice: valid bit plus data, address and overflow payload.
module dadd_stage
  import dadd_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              v_in,
  input  logic [DWIDTH-1:0] d_in,
  input  logic [AWIDTH-1:0] a_in,
  input  logic              o_in,
  output logic              v,
  output logic [DWIDTH-1:0] data,
  output logic [AWIDTH-1:0] addr,
  output logic              ovf
);

  // Payload only moves with a valid beat, so a drained slice keeps its last fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= 1'b0;
      data <= '0;
      addr <= '0;
      ovf  <= 1'b0;
    end else if (load) begin
      v <= v_in;
      if (v_in) begin
        data <= d_in;
        addr <= a_in;
        ovf  <= o_in;
      end
    end
  end

endmodule

// File: rtl/dadd_pipe.sv
// Add/subtract (wrap or saturate) on a data word, carried through a STAGES-deep
// valid/ready pipeline with bubble collapse, plus beat and overflow counters.
module dadd_pipe
  import dadd_pkg::*;
#(
  parameter int AWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DWIDTH-1:0]    in_data,
  input  logic [AWIDTH-1:0]    in_addr,
  input  logic [1:0]           in_mode,
  input  logic [DWIDTH-1:0]    add_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DWIDTH-1:0]    out_data,
  output logic [AWIDTH-1:0]    out_addr,
  output logic                 out_ovf,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic [CNT_WIDTH-1:0] ovf_cnt
);

  generate
    if (STAGES < 1 || STAGES > DADD_MAX_STAGES) begin : g_bad_stages
      $error("dadd_pipe: STAGES must be in 1..DADD_MAX_STAGES");
    end
  endgenerate

  dadd_mode_e        mode;
  logic [DWIDTH:0]   sum;
  logic [DWIDTH:0]   diff;
  logic [DWIDTH-1:0] res_data;
  logic              res_ovf;

  assign mode = dadd_mode_e'(in_mode);

  // Carry and borrow both appear as the extra top bit of the DWIDTH+1 result.
  always_comb begin
    sum      = {1'b0, in_data} + {1'b0, add_val};
    diff     = {1'b0, in_data} - {1'b0, add_val};
    res_data = '0;
    res_ovf  = 1'b0;
    case (mode)
      DADD_ADD_WRAP: begin res_data = sum[DWIDTH-1:0];  res_ovf = sum[DWIDTH];  end
      DADD_ADD_SAT:  begin res_data = sum[DWIDTH] ? '1 : sum[DWIDTH-1:0]; res_ovf = sum[DWIDTH]; end
      DADD_SUB_WRAP: begin res_data = diff[DWIDTH-1:0]; res_ovf = diff[DWIDTH]; end
      DADD_SUB_SAT:  begin res_data = diff[DWIDTH] ? '0 : diff[DWIDTH-1:0]; res_ovf = diff[DWIDTH]; end
      default:       begin res_data = '0; res_ovf = 1'b0; end
    endcase
  end

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1;
  // valid never waits on ready, and a held beat keeps its fields stable until taken.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] o_in;
  logic [STAGES-1:0] ovf_s;
  logic [DWIDTH-1:0] d_in   [STAGES];
  logic [DWIDTH-1:0] data_s [STAGES];
  logic [AWIDTH-1:0] a_in   [STAGES];
  logic [AWIDTH-1:0] addr_s [STAGES];
  logic [STAGES:0]   load;

  // load[i]: stage i may take a new beat because it is empty or it is draining.
  always_comb begin
    load         = '0;
    load[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i] = ~v[i] | load[i+1];
    end
  end

  assign in_ready = rst_n & load[0];

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_head
        assign v_in[i] = in_valid;
        assign d_in[i] = res_data;
        assign a_in[i] = in_addr;
        assign o_in[i] = res_ovf;
      end else begin : g_tail
        assign v_in[i] = v[i-1];
        assign d_in[i] = data_s[i-1];
        assign a_in[i] = addr_s[i-1];
        assign o_in[i] = ovf_s[i-1];
      end

      dadd_stage #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load[i]),
        .v_in  (v_in[i]),
        .d_in  (d_in[i]),
        .a_in  (a_in[i]),
        .o_in  (o_in[i]),
        .v     (v[i]),
        .data  (data_s[i]),
        .addr  (addr_s[i]),
        .ovf   (ovf_s[i])
      );
    end
  endgenerate

  assign out_valid = v[STAGES-1];
  assign out_data  = data_s[STAGES-1];
  assign out_addr  = addr_s[STAGES-1];
  assign out_ovf   = ovf_s[STAGES-1];

  logic out_hs;
  assign out_hs = out_valid & out_ready;

  // Clear wins over a same-cycle handshake; the overflow count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      ovf_cnt  <= '0;
    end else if (cnt_clr) begin
      beat_cnt <= '0;
      ovf_cnt  <= '0;
    end else if (out_hs) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (out_ovf && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dadd_pipe.sv
// Bench for dadd_pipe: directed cases plus randomized traffic against a
// queue-based arithmetic reference model.
module tb_dadd_pipe;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ST = 2;
  localparam int CW = 16;
  localparam int W  = DW + AW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_addr = '0;
  logic [1:0]    in_mode = '0;
  logic [DW-1:0] add_val = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_ovf;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] ovf_cnt;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [CW-1:0] m_beat = '0;
  logic [CW-1:0] m_ovf = '0;
  logic          in_taken = 1'b0;
  logic          have_hold = 1'b0;
  logic [W-1:0]  held = '0;

  dadd_pipe #(.AWIDTH(AW), .DWIDTH(DW), .STAGES(ST), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_mode   (in_mode),
    .add_val   (add_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_ovf   (out_ovf),
    .cnt_clr   (cnt_clr),
    .beat_cnt  (beat_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [W-1:0] ref_beat(input logic [DW-1:0] d, input logic [DW-1:0] a,
                                            input logic [1:0] m, input logic [AW-1:0] ad);
    longint unsigned x, y, r, maxv;
    logic [DW-1:0] res;
    logic o;
    x = longint'(d);
    y = longint'(a);
    maxv = 64'h0000_0000_FFFF_FFFF;
    if (m[1] == 1'b0) begin
      r = x + y;
      o = (r > maxv);
      res = (o && m[0]) ? DW'(maxv) : DW'(r);
    end else begin
      o = (y > x);
      r = x - y;
      res = (o && m[0]) ? '0 : DW'(r);
    end
    return {o, ad, res};
  endfunction

  // ---------------- scoreboard / monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic hs;
    logic e_ovf;
    if (!rst_n) begin
      exp_q.delete();
      m_beat = '0;
      m_ovf = '0;
      in_taken = 1'b0;
      have_hold = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_beat_cnt", beat_cnt, 0);
      check("rst_ovf_cnt", ovf_cnt, 0);
    end else begin
      check("beat_cnt", beat_cnt, m_beat);
      check("ovf_cnt", ovf_cnt, m_ovf);
      check("in_ready", in_ready, (exp_q.size() < ST) || out_ready);
      if (have_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_fields", {out_ovf, out_addr, out_data}, held);
      end
      hs = out_valid && out_ready;
      e_ovf = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          e_ovf = e[W-1];
          check("out_beat", {out_ovf, out_addr, out_data}, e);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_beat(in_data, add_val, in_mode, in_addr));
      in_taken = in_valid && in_ready;
      if (cnt_clr) begin
        m_beat = '0;
        m_ovf = '0;
      end else if (hs) begin
        m_beat = m_beat + 1'b1;
        if (e_ovf && m_ovf != '1) m_ovf = m_ovf + 1'b1;
      end
      have_hold = out_valid && !out_ready;
      held = {out_ovf, out_addr, out_data};
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] a,
                      input logic [1:0] m, input logic [AW-1:0] ad);
    int n;
    in_valid = 1'b1;
    in_data = d;
    add_val = a;
    in_mode = m;
    in_addr = ad;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", n, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] a,
                          input logic [1:0] m, input logic [AW-1:0] ad,
                          input logic [DW-1:0] exp_d, input logic exp_o);
    int lat;
    out_ready = 1'b1;
    send(d, a, m, ad);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, ST);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_addr"}, out_addr, ad);
    check({tag, "_ovf"}, out_ovf, exp_o);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (ST + 3) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [CW-1:0] b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op_check("add_wrap", 32'h5, 32'h1, 2'b00, 32'h10, 32'h6, 1'b0);
    op_check("add_wrap_ovf", 32'hFFFF_FFFF, 32'h1, 2'b00, 32'h20, 32'h0, 1'b1);
    op_check("add_sat_ovf", 32'hFFFF_FFFF, 32'h1, 2'b01, 32'h24, 32'hFFFF_FFFF, 1'b1);
    op_check("sub_wrap_ovf", 32'h3, 32'h5, 2'b10, 32'h30, 32'hFFFF_FFFE, 1'b1);
    op_check("sub_sat_ovf", 32'h3, 32'h5, 2'b11, 32'h34, 32'h0, 1'b1);
    op_check("sub_wrap", 32'h9, 32'h5, 2'b10, 32'h38, 32'h4, 1'b0);

    // Stream 1..6 (+1) with the sink stalled for 5 cycles from cycle 2.
    b0 = beat_cnt;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(DW'(i), 32'h1, 2'b00, AW'(32'h100 + i));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_beats", beat_cnt - b0, 6);
    check("stall_empty", exp_q.size(), 0);

    // Counters: 10 beats with 3 overflows, then clear on an 11th handshake.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3) send(32'hFFFF_FFF0, 32'h100, 2'b00, AW'(i));
      else send(DW'(i), 32'h1, 2'b00, AW'(i));
    end
    drain();
    check("cnt_beats10", beat_cnt, 10);
    check("cnt_ovf3", ovf_cnt, 3);
    send(32'hFFFF_FFFF, 32'h2, 2'b00, 32'h55);
    repeat (ST - 1) @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr_beat_cnt", beat_cnt, 0);
    check("clr_ovf_cnt", ovf_cnt, 0);
    check("clr_beat_left", out_valid, 0);

    // Randomized traffic with random backpressure and occasional clears.
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || in_taken) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: in_data = '0;
          1: in_data = '1;
          2: in_data = DW'($urandom_range(0, 15));
          default: in_data = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0: add_val = '0;
          1: add_val = '1;
          2: add_val = DW'($urandom_range(0, 15));
          default: add_val = $urandom;
        endcase
        in_mode = 2'($urandom_range(0, 3));
        in_addr = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    drain();
    check("rand_empty", exp_q.size(), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(32'h7, 32'h1, 2'b00, 32'hA0);
    send(32'h8, 32'h1, 2'b00, 32'hA4);
    check("pre_rst_full", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_beat_cnt", beat_cnt, 0);
    check("rst_mid_ovf_cnt", ovf_cnt, 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_beat", beat_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dadd_pipe.md
Name: dadd_pipe

Overview:
Parametrised successor to the single-cycle data-increment block. It adds or subtracts a per-beat operand to a data word, with wrap or saturate modes, and carries an address alongside the data. It is a STAGES-deep pipeline with valid/ready backpressure, per-stage bubble collapse and an overflow flag, plus beat and overflow counters. It sits between a data source and sink on the same datapath.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data/operand width
STAGES, 2, pipeline depth, legal 1..8
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid & in_ready
in_data  input  DWIDTH  data word
in_addr  input  AWIDTH  address, passed through unchanged
in_mode  input  2  op select, sampled with beat
add_val  input  DWIDTH  operand, sampled with beat
out_valid  output  1  output beat valid
out_ready  input  1  sink accepts when out_valid & out_ready
out_data  output  DWIDTH  result
out_addr  output  AWIDTH  address of this beat
out_ovf  output  1  carry/borrow occurred for this beat
cnt_clr  input  1  synchronous clear of both counters
beat_cnt  output  CNT_WIDTH  count of output handshakes
ovf_cnt  output  CNT_WIDTH  count of output handshakes with out_ovf=1

Behaviour:
- Reset (async assert, sync use after deassert): all stage valids 0, data/addr/ovf regs 0, counters 0. out_valid=0, out_data=0, out_addr=0, out_ovf=0. in_ready forced 0 while rst_n low.
- Reset mid-operation discards all in-flight beats. None emerge after reset.
- Modes: 00 wrap add (in_data+add_val mod 2^DWIDTH). 01 saturating add (clamp all-ones). 10 wrap sub (in_data-add_val mod 2^DWIDTH). 11 saturating sub (clamp 0).
- ovf = carry-out (add) or borrow (sub). It is computed on DWIDTH+1 bits and is set in both wrap and sat modes.
- Arithmetic is done combinationally before stage 0 register. Stages 1..STAGES-1 only delay data, addr and ovf.
- Stage i holds (v[i], data, addr, ovf). Stage i loads from i-1 when ~v[i] | adv[i+1]. adv[STAGES] = out_ready.
- in_ready = ~v[0] | adv[1]. A bubble in any stage is filled even while the output is stalled.
- out_valid = v[STAGES-1]. Output fields are held stable while out_valid & ~out_ready.
- Latency: accepted beat appears on out_valid exactly STAGES cycles later with no backpressure. Throughput is 1 beat/cycle.
- Ordering: strict FIFO order. No loss, no duplication.
- Full: all STAGES valid and out_ready=0 gives in_ready=0. Simultaneous out handshake and in handshake on full pipe is allowed (pass-through).
- beat_cnt: +1 per output handshake, wraps at 2^CNT_WIDTH.
- ovf_cnt: +1 per output handshake with out_ovf=1, saturates at all-ones.
- cnt_clr: both counters become 0 next cycle. cnt_clr takes priority over a same-cycle handshake, so that beat is not counted.
- in_mode/add_val are don't-care when no input handshake.

Decomposition:
- Package dadd_pkg: typedef enum logic[1:0] dadd_mode_e {DADD_ADD_WRAP, DADD_ADD_SAT, DADD_SUB_WRAP, DADD_SUB_SAT}.
- Package dadd_pkg also holds constant DADD_MAX_STAGES=8, for an elaboration check on STAGES.
- Sub-module dadd_stage: one register slice (valid, data, addr, ovf), with inputs load and v_in. It is instantiated STAGES times in a generate loop. Arithmetic and counters stay in dadd_pipe.

Test Plan:
- Mode 00, in_data=0x5, add_val=0x1, in_addr=0x10, out_ready=1 -> 2 cycles later out_data=0x6, out_addr=0x10, out_ovf=0.
- in_data=0xFFFF_FFFF, add_val=1: mode 00 -> out_data=0x0, ovf=1. Mode 01 -> out_data=0xFFFF_FFFF, ovf=1.
- in_data=3, add_val=5: mode 10 -> 0xFFFF_FFFE, ovf=1. Mode 11 -> 0x0, ovf=1. Mode 10 with data 9 -> 0x4, ovf=0.
- Stream 6 beats (data 1..6), out_ready=0 for 5 cycles from cycle 2 -> in_ready drops after 2 beats held. Outputs stay stable, then 2..7 emerge in order with no gaps or duplicates.
- Counters: 10 beats, 3 overflowing -> beat_cnt=10, ovf_cnt=3. cnt_clr coincident with an 11th handshake -> both read 0 next cycle.
- Two beats in flight, pulse rst_n low 1 cycle -> out_valid=0 immediately, counters=0, no beat emerges after release, in_ready=1 after release.
